// File: rtl/scg_self_ref_ctrl.sv
`timescale 1ns/1ps
// Self-refresh sequencer: idle detection, entry/exit FSM handshake, residency and tXSR recovery.
// Optional entry/exit handshake timeout is compiled in when SCG_SR_TIMEOUT_EN is defined.
module scg_self_ref_ctrl #(
    parameter int IDLE_CYCLES    = 1024,
    parameter int MIN_SR_CYCLES  = 16,
    parameter int TXSR_CYCLES    = 10,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       sr_en,
    input  logic       bus_busy,
    input  logic       wake_req,
    input  logic       entry_done,
    input  logic       exit_done,
    input  logic [3:0] entry_cmd,
    input  logic [3:0] exit_cmd,
    output logic       start_entry,
    output logic       start_exit,
    output logic [3:0] command,
    output logic       in_sr,
    output logic       sr_ready,
    output logic       sr_error
);

    localparam int MAX_AB = (IDLE_CYCLES > MIN_SR_CYCLES) ? IDLE_CYCLES : MIN_SR_CYCLES;
    localparam int MAX_CD = (TXSR_CYCLES > TIMEOUT_CYCLES) ? TXSR_CYCLES : TIMEOUT_CYCLES;
    localparam int MAX_P  = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int CNT_W  = $clog2(MAX_P) + 1;

    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] MIN_LAST  = CNT_W'(MIN_SR_CYCLES - 1);
    localparam logic [CNT_W-1:0] TXSR_LAST = CNT_W'(TXSR_CYCLES - 1);
`ifdef SCG_SR_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
`endif

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ENTER,
        ST_SELF_REF,
        ST_EXIT,
        ST_RECOVER
    } state_t;

    state_t           state_reg;
    state_t           state_next;
    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;
    logic             error_reg;
    logic             error_next;
    logic             start_entry_reg;
    logic             start_exit_reg;
    logic             in_sr_reg;
    logic             sr_ready_reg;
    logic             qualify;

    assign qualify = sr_en & ~bus_busy & ~wake_req;

    // Next-state logic; the shared counter is cleared on every state change.
    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        error_next = error_reg;
        case (state_reg)
            ST_IDLE: begin
                if (!qualify) begin
                    count_next = '0;
                end else if (count_reg == IDLE_LAST) begin
                    state_next = ST_ENTER;
                    count_next = '0;
                end else begin
                    count_next = count_reg + CNT_ONE;
                end
            end
            ST_ENTER: begin
                if (entry_done) begin
                    state_next = ST_SELF_REF;
                    count_next = '0;
                end
`ifdef SCG_SR_TIMEOUT_EN
                else if (count_reg == TO_LAST) begin
                    state_next = ST_RECOVER;
                    count_next = '0;
                    error_next = 1'b1;
                end else begin
                    count_next = count_reg + CNT_ONE;
                end
`endif
            end
            ST_SELF_REF: begin
                // Residency counter saturates once the minimum has been met.
                if (count_reg >= MIN_LAST) begin
                    if (wake_req || !sr_en) begin
                        state_next = ST_EXIT;
                        count_next = '0;
                    end
                end else begin
                    count_next = count_reg + CNT_ONE;
                end
            end
            ST_EXIT: begin
                if (exit_done) begin
                    state_next = ST_RECOVER;
                    count_next = '0;
                end
`ifdef SCG_SR_TIMEOUT_EN
                else if (count_reg == TO_LAST) begin
                    state_next = ST_RECOVER;
                    count_next = '0;
                    error_next = 1'b1;
                end else begin
                    count_next = count_reg + CNT_ONE;
                end
`endif
            end
            ST_RECOVER: begin
                if (count_reg == TXSR_LAST) begin
                    state_next = ST_IDLE;
                    count_next = '0;
                end else begin
                    count_next = count_reg + CNT_ONE;
                end
            end
            default: begin
                state_next = ST_IDLE;
                count_next = '0;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with state_reg.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_reg       <= ST_IDLE;
            count_reg       <= '0;
            error_reg       <= 1'b0;
            start_entry_reg <= 1'b0;
            start_exit_reg  <= 1'b0;
            in_sr_reg       <= 1'b0;
            sr_ready_reg    <= 1'b1;
        end else begin
            state_reg       <= state_next;
            count_reg       <= count_next;
            error_reg       <= error_next;
            start_entry_reg <= (state_next == ST_ENTER);
            start_exit_reg  <= (state_next == ST_EXIT);
            in_sr_reg       <= (state_next == ST_SELF_REF) || (state_next == ST_EXIT);
            sr_ready_reg    <= (state_next == ST_IDLE);
        end
    end

    assign start_entry = start_entry_reg;
    assign start_exit  = start_exit_reg;
    assign in_sr       = in_sr_reg;
    assign sr_ready    = sr_ready_reg;
    assign sr_error    = error_reg;

    // Command mux: the start flags are one-hot-or-zero, so an AND-OR per bit suffices.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_cmd
            assign command[gi] = (start_entry_reg & entry_cmd[gi]) |
                                 (start_exit_reg  & exit_cmd[gi]);
        end
    endgenerate

endmodule

// File: tb/tb_scg_self_ref_ctrl.sv
`timescale 1ns/1ps
// Bench for scg_self_ref_ctrl: phase/elapsed-time model checked every cycle plus directed duration checks.
module tb_scg_self_ref_ctrl;

    localparam int IDLE_C = 8;
    localparam int MIN_C  = 4;
    localparam int TXSR_C = 10;
    localparam int TO_C   = 16;
`ifdef SCG_SR_TIMEOUT_EN
    localparam bit TO_ON = 1'b1;
`else
    localparam bit TO_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       n_rst;
    logic       sr_en;
    logic       bus_busy;
    logic       wake_req;
    logic       entry_done = 1'b0;
    logic       exit_done = 1'b0;
    logic [3:0] entry_cmd = 4'h0;
    logic [3:0] exit_cmd = 4'h0;
    logic       start_entry;
    logic       start_exit;
    logic [3:0] command;
    logic       in_sr;
    logic       sr_ready;
    logic       sr_error;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    scg_self_ref_ctrl #(
        .IDLE_CYCLES   (IDLE_C),
        .MIN_SR_CYCLES (MIN_C),
        .TXSR_CYCLES   (TXSR_C),
        .TIMEOUT_CYCLES(TO_C)
    ) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .sr_en      (sr_en),
        .bus_busy   (bus_busy),
        .wake_req   (wake_req),
        .entry_done (entry_done),
        .exit_done  (exit_done),
        .entry_cmd  (entry_cmd),
        .exit_cmd   (exit_cmd),
        .start_entry(start_entry),
        .start_exit (start_exit),
        .command    (command),
        .in_sr      (in_sr),
        .sr_ready   (sr_ready),
        .sr_error   (sr_error)
    );

    task automatic chk_b(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b expected=%b t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_c(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_n(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    // Stand-ins for the entry/exit FSMs: done after a set number of start cycles (0 = never).
    int entry_lat = 3;
    int exit_lat  = 11;
    int ent_run   = 0;
    int ext_run   = 0;
    int cyc       = 0;
    bit spurious  = 1'b0;

    always @(posedge clk) begin
        #1;
        cyc++;
        entry_cmd  = 4'(cyc) | 4'h8;
        exit_cmd   = 4'(cyc * 3) | 4'h1;
        ent_run    = start_entry ? ent_run + 1 : 0;
        ext_run    = start_exit ? ext_run + 1 : 0;
        entry_done = (spurious && !start_entry) ||
                     (start_entry && entry_lat > 0 && ent_run >= entry_lat);
        exit_done  = (spurious && !start_exit) ||
                     (start_exit && exit_lat > 0 && ext_run >= exit_lat);
    end

    // Model: which phase we are in, how many cycles have elapsed in it, and the idle streak.
    typedef enum int {M_IDLE, M_ENTER, M_SR, M_EXIT, M_REC} mphase_t;
    mphase_t ph = M_IDLE;
    int      age = 0;
    int      streak = 0;
    bit      err = 1'b0;
    bit      model_valid = 1'b0;

    task go(input mphase_t p);
        ph = p;
        age = 0;
        streak = 0;
    endtask

    always @(posedge clk) begin
        model_valid = 1'b1;
        if (!n_rst) begin
            go(M_IDLE);
            err = 1'b0;
        end else begin
            age++;
            case (ph)
                M_IDLE: begin
                    age = 0;
                    streak = (sr_en && !bus_busy && !wake_req) ? streak + 1 : 0;
                    if (streak == IDLE_C) go(M_ENTER);
                end
                M_ENTER: begin
                    if (entry_done) go(M_SR);
                    else if (TO_ON && age == TO_C) begin err = 1'b1; go(M_REC); end
                end
                M_SR: if (age >= MIN_C && (wake_req || !sr_en)) go(M_EXIT);
                M_EXIT: begin
                    if (exit_done) go(M_REC);
                    else if (TO_ON && age == TO_C) begin err = 1'b1; go(M_REC); end
                end
                M_REC: if (age == TXSR_C) go(M_IDLE);
                default: go(M_IDLE);
            endcase
        end
    end

    always @(negedge clk) begin
        if (model_valid) begin
            chk_b("start_entry", start_entry, ph == M_ENTER);
            chk_b("start_exit", start_exit, ph == M_EXIT);
            chk_b("in_sr", in_sr, ph == M_SR || ph == M_EXIT);
            chk_b("sr_ready", sr_ready, ph == M_IDLE);
            chk_b("sr_error", sr_error, err);
            chk_c("command", command,
                  (ph == M_ENTER) ? entry_cmd : (ph == M_EXIT) ? exit_cmd : 4'h0);
        end
    end

    function automatic bit cond(input int which);
        case (which)
            0:       return start_entry === 1'b1;
            1:       return in_sr === 1'b1 && command === 4'h0 && start_exit === 1'b0;
            2:       return start_exit === 1'b1;
            3:       return sr_ready === 1'b0;
            default: return 1'b0;
        endcase
    endfunction

    // Cycles (starting with the current one) before cond becomes true.
    task automatic wait_for(input int which, input string name, input int exp);
        int n = 0;
        while (!cond(which) && n < 300) begin
            n++;
            @(negedge clk);
        end
        chk_n(name, n, exp);
    endtask

    // Cycles (starting with the current one) for which cond stays true.
    task automatic measure(input int which, input string name, input int exp);
        int n = 0;
        if (cond(which)) begin
            n = 1;
            while (n < 300) begin
                @(negedge clk);
                if (!cond(which)) break;
                n++;
            end
        end
        chk_n(name, n, exp);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_rst = 1'b0;
        sr_en = 1'b0;
        bus_busy = 1'b0;
        wake_req = 1'b0;
        repeat (3) @(negedge clk);
        chk_b("rst_sr_ready", sr_ready, 1'b1);
        chk_b("rst_start_entry", start_entry, 1'b0);
        chk_b("rst_in_sr", in_sr, 1'b0);
        chk_c("rst_command", command, 4'h0);
        chk_b("rst_sr_error", sr_error, 1'b0);

        // Idle qualification, entry, wake held through self-refresh
        sr_en = 1'b1;
        n_rst = 1'b1;
        wait_for(0, "idle_to_enter", 8);
        wake_req = 1'b1;
        measure(0, "enter_len", 3);
        measure(1, "sr_len_wake", 4);
        chk_c("exit_cmd_muxed", command, exit_cmd);
        measure(2, "exit_len", 11);
        chk_c("recover_cmd", command, 4'h0);
        chk_b("recover_start_exit", start_exit, 1'b0);
        measure(3, "recover_len", 10);
        chk_b("idle_ready", sr_ready, 1'b1);
        chk_b("idle_in_sr", in_sr, 1'b0);

        // bus_busy restarts the idle count; wake raised during ENTER; stray done flags
        wake_req = 1'b0;
        spurious = 1'b1;
        repeat (4) @(negedge clk);
        bus_busy = 1'b1;
        @(negedge clk);
        bus_busy = 1'b0;
        wait_for(0, "busy_restart", 8);
        wake_req = 1'b1;
        measure(0, "enter_len_wake", 3);
        measure(1, "sr_len_wake_in_enter", 4);
        measure(2, "exit_len2", 11);
        measure(3, "recover_len2", 10);
        spurious = 1'b0;

        // sr_en dropped in self-refresh with no wake
        wake_req = 1'b0;
        exit_lat = 2;
        wait_for(0, "reentry_full_idle", 8);
        measure(0, "enter_len3", 3);
        sr_en = 1'b0;
        measure(1, "sr_len_sren", 4);
        measure(2, "exit_len_short", 2);
        measure(3, "recover_len3", 10);
        repeat (20) @(negedge clk);
        chk_b("idle_hold_sr_en0", start_entry, 1'b0);

        // Late wake extends residency; reset mid-exit
        sr_en = 1'b1;
        exit_lat = 11;
        wait_for(0, "entry4", 8);
        measure(0, "enter_len4", 3);
        repeat (5) @(negedge clk);
        chk_b("sr_no_request_stays", in_sr, 1'b1);
        wake_req = 1'b1;
        measure(1, "sr_late_wake_tail", 1);
        repeat (4) @(negedge clk);
        n_rst = 1'b0;
        @(negedge clk);
        chk_b("midexit_rst_start_exit", start_exit, 1'b0);
        chk_c("midexit_rst_command", command, 4'h0);
        chk_b("midexit_rst_in_sr", in_sr, 1'b0);
        chk_b("midexit_rst_sr_ready", sr_ready, 1'b1);
        n_rst = 1'b1;
        wake_req = 1'b0;

`ifdef SCG_SR_TIMEOUT_EN
        // Entry never completes
        entry_lat = 0;
        wait_for(0, "to_entry_wait", 8);
        measure(0, "to_enter_len", 16);
        chk_b("to_sr_error_set", sr_error, 1'b1);
        chk_b("to_in_sr", in_sr, 1'b0);
        measure(3, "to_recover_len", 10);
        chk_b("to_sr_error_sticky", sr_error, 1'b1);
        sr_en = 1'b0;
        repeat (5) @(negedge clk);
        chk_b("to_sr_error_sticky2", sr_error, 1'b1);
        n_rst = 1'b0;
        @(negedge clk);
        chk_b("to_sr_error_cleared", sr_error, 1'b0);
        n_rst = 1'b1;
        sr_en = 1'b1;

        // Done on the timeout cycle wins; then the exit times out
        entry_lat = 16;
        exit_lat = 0;
        wait_for(0, "tie_entry_wait", 8);
        measure(0, "tie_enter_len", 16);
        chk_b("tie_no_error", sr_error, 1'b0);
        chk_b("tie_in_sr", in_sr, 1'b1);
        wake_req = 1'b1;
        measure(1, "tie_sr_len", 4);
        measure(2, "to_exit_len", 16);
        chk_b("to_exit_error", sr_error, 1'b1);
        measure(3, "to_exit_recover_len", 10);
        wake_req = 1'b0;
`endif

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/scg_self_ref_ctrl.md
Name: scg_self_ref_ctrl

Overview:
Self-refresh sequencer that sits directly upstream of scg_self_ref_exit and its sibling scg_self_ref_entry in the SDRAM command-generation path. It watches bus activity and enters self-refresh after a programmable idle period. It drives the start inputs of the entry and exit FSMs and consumes their done flags. It muxes their command outputs onto a single command bus, enforces minimum self-refresh residency and tXSR recovery, and reports when the main controller may issue commands again.

Parameters:
IDLE_CYCLES, 1024, consecutive qualifying idle cycles required before entering self-refresh (>=2)
MIN_SR_CYCLES, 16, minimum cycles spent in SELF_REF before exit may start (>=1)
TXSR_CYCLES, 10, NOP cycles after exit_done before sr_ready reasserts (>=1)
TIMEOUT_CYCLES, 64, cycles allowed for entry/exit done (used only with optional feature)

Ports:
clk  in  1  system clock, all logic on rising edge
n_rst  in  1  synchronous active-low reset, sampled on rising clk
sr_en  in  1  auto self-refresh permitted
bus_busy  in  1  main controller has an access in flight
wake_req  in  1  pending access requires leaving self-refresh
entry_done  in  1  done from scg_self_ref_entry
exit_done  in  1  done from scg_self_ref_exit
entry_cmd  in  4  command from entry FSM
exit_cmd  in  4  command from exit FSM
start_entry  out  1  level start to entry FSM
start_exit  out  1  level start to exit FSM
command  out  4  muxed SDRAM command, 4'd0 = NOP
in_sr  out  1  device is in self-refresh
sr_ready  out  1  main controller may issue commands
sr_error  out  1  sticky handshake timeout (optional feature)

Behaviour:
- Moore FSM. All outputs decode from registered state and counters. No input-to-output combinational paths except the command mux select.
- States: IDLE, ENTER, SELF_REF, EXIT, RECOVER. A single counter of width clog2(max param)+1 is shared and cleared on every state change.
- Reset (n_rst=0 at rising edge): state=IDLE, counter=0, start_entry=0, start_exit=0, command=0, in_sr=0, sr_ready=1, sr_error=0. Reset in any state aborts the sequence immediately.
- IDLE: sr_ready=1, command=0.
  - A qualifying cycle has sr_en=1, bus_busy=0 and wake_req=0. Each qualifying cycle increments the counter; any non-qualifying cycle clears it.
  - A qualifying cycle with counter==IDLE_CYCLES-1 moves to ENTER. ENTER is therefore reached after exactly IDLE_CYCLES consecutive qualifying cycles.
- ENTER: start_entry=1, command=entry_cmd, sr_ready=0.
  - entry_done=1 moves to SELF_REF.
  - wake_req and sr_en are ignored; entry always completes.
- SELF_REF: in_sr=1, command=0, sr_ready=0, and the counter counts.
  - Once counter>=MIN_SR_CYCLES-1, (wake_req=1 or sr_en=0) moves to EXIT.
  - A wake_req asserted earlier is honoured when the minimum expires, even if it was seen during ENTER; this is level-sensitive with no latching.
- EXIT: start_exit=1, command=exit_cmd, in_sr=1, sr_ready=0.
  - exit_done=1 moves to RECOVER.
- RECOVER: command=0, in_sr=0, sr_ready=0.
  - Counts TXSR_CYCLES cycles, then moves to IDLE with the counter cleared. sr_ready rises on the first IDLE cycle.
  - The IDLE counter restarts from 0; re-entry requires a full IDLE_CYCLES.
- Done flags are ignored outside their own state. Start signals drop the cycle after the matching done is sampled.
- bus_busy during ENTER/SELF_REF/EXIT/RECOVER is ignored. The main controller must gate on sr_ready.

Optional Feature:
SCG_SR_TIMEOUT_EN
- Defined:
  - Counts cycles in ENTER and EXIT. If done has not been seen after TIMEOUT_CYCLES cycles, sr_error is set to 1 (sticky until reset) and the state is forced to RECOVER.
  - A done arriving on the same cycle as the timeout takes priority: normal transition, no error.
- Not defined: no timeout logic, sr_error tied to 0, ENTER/EXIT wait indefinitely.

Test Plan:
- Use IDLE_CYCLES=8, MIN_SR_CYCLES=4, TXSR_CYCLES=10, TIMEOUT_CYCLES=16 throughout.
- Reset then sr_en=1, bus_busy=0 -> sr_ready=1 for 8 cycles; start_entry=1 and command=entry_cmd on the 9th. With bus_busy pulsed at cycle 5, the count restarts and entry occurs 8 cycles after the pulse ends.
- Entry FSM returns entry_done after 3 cycles, wake_req=1 held -> in_sr=1 with command=0 for exactly 4 cycles; then start_exit=1 and command=exit_cmd.
- exit_done after 11 cycles (mirrors exit FSM bench) -> start_exit drops the next cycle; command=0 and sr_ready=0 for 10 cycles; then sr_ready=1 and in_sr=0.
- wake_req=1 asserted during ENTER -> entry completes; SELF_REF still lasts 4 cycles; exit follows. sr_en dropped in SELF_REF with wake_req=0 -> exit after the minimum.
- n_rst=0 mid-EXIT -> next cycle: start_exit=0, command=0, in_sr=0, sr_ready=1, state IDLE.
- With SCG_SR_TIMEOUT_EN, entry_done never asserted -> sr_error=1 after 16 ENTER cycles, then RECOVER for 10 cycles, then IDLE. sr_error remains 1 until reset.
